// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the serial arithmetic blocks.
//   DEFAULT_WIDTH : default operand/result width
//   state_t       : sequencing FSM states (IDLE -> RUN -> DONE -> IDLE)
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// ---------------------------------------------------------------------------
// half_subtractor
// Combinational one-bit subtract cell, the counterpart of half_adder.
//   a      : minuend bit
//   b      : subtrahend bit
//   diff   : a ^ b
//   borrow : ~a & b
// ---------------------------------------------------------------------------
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b;
    assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock, with a start/done handshake.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request, sampled only in IDLE
//   a, b   : operands, captured on the accepted start
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse, result valid
//   diff   : registered result, updated only on completion
//   borrow : registered, 1 iff a < b
// ---------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    // Only the upper WIDTH-1 bits of the partial result need storing: the
    // bit produced on the final edge goes straight into diff.
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bff;
    logic [CW-1:0]    r_cnt;

    logic             w_d0;
    logic             w_b0;
    logic             w_d;
    logic             w_b1;
    logic             w_bo;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtract cell: (sa - sb) then (partial - borrow_in).
    half_subtractor u_hs0 (
        .a      (r_sa[0]),
        .b      (r_sb[0]),
        .diff   (w_d0),
        .borrow (w_b0)
    );

    half_subtractor u_hs1 (
        .a      (w_d0),
        .b      (r_bff),
        .diff   (w_d),
        .borrow (w_b1)
    );

    assign w_bo       = w_b0 | w_b1;
    assign w_last     = (r_cnt == LAST);
    assign w_res_next = {w_d, r_res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bff    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa  <= a;
                        r_sb  <= b;
                        r_bff <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_bff <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
